// File: rtl/register_file.sv
// rtl/register_file.sv - two-read one-write register file with async active-low reset
module register_file #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  Clock,
    input  logic                  nReset,
    input  logic [ADDR_WIDTH-1:0] AddressA,
    input  logic [ADDR_WIDTH-1:0] AddressB,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  WriteEnable,
    output logic [DATA_WIDTH-1:0] ReadDataA,
    output logic [DATA_WIDTH-1:0] ReadDataB
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_registers [DEPTH];

    // Storage: reset clears every entry at once; otherwise one entry per edge on write.
    // Port A's address doubles as the write target, so both share one decoder input.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_registers[i] <= '0;
            end
        end else if (WriteEnable) begin
            r_registers[AddressA] <= WriteData;
        end
    end

    // Reads are pure muxes off the array with no write bypass: a write becomes
    // visible only after the edge that stores it. During reset the array is
    // already zero, so the outputs read zero without extra gating.
    assign ReadDataA = r_registers[AddressA];
    assign ReadDataB = r_registers[AddressB];

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - table-driven self-checking bench for register_file
module tb_register_file;

    logic        Clock;
    logic        nReset;
    logic [5:0]  AddressA;
    logic [5:0]  AddressB;
    logic [15:0] WriteData;
    logic        WriteEnable;
    logic [15:0] ReadDataA;
    logic [15:0] ReadDataB;

    int n_vec;
    int n_err;

    typedef struct {
        logic        we;
        logic [5:0]  addr_a;
        logic [5:0]  addr_b;
        logic [15:0] wdata;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
    } vec_t;

    vec_t vecs [13];

    register_file #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(6)
    ) dut (
        .Clock      (Clock),
        .nReset     (nReset),
        .AddressA   (AddressA),
        .AddressB   (AddressB),
        .WriteData  (WriteData),
        .WriteEnable(WriteEnable),
        .ReadDataA  (ReadDataA),
        .ReadDataB  (ReadDataB)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic sweep_zero(input string name);
        for (int i = 0; i < 64; i++) begin
            AddressA = 6'(i);
            AddressB = 6'(63 - i);
            #1;
            check({name, "_a"}, ReadDataA, 16'h0000);
            check({name, "_b"}, ReadDataB, 16'h0000);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        //            we    a   b   wdata     exp_a     exp_b
        vecs[0]  = '{1'b1,  1,  1, 16'h3D3A, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b0,  1,  1, 16'h0000, 16'h3D3A, 16'h3D3A};
        vecs[2]  = '{1'b1,  6,  1, 16'h000A, 16'h0000, 16'h3D3A};
        vecs[3]  = '{1'b0,  6,  1, 16'h0000, 16'h000A, 16'h3D3A};
        vecs[4]  = '{1'b0,  0,  6, 16'h0000, 16'h0000, 16'h000A};
        vecs[5]  = '{1'b0,  6,  6, 16'hFFFF, 16'h000A, 16'h000A};
        vecs[6]  = '{1'b0,  6,  6, 16'hFFFF, 16'h000A, 16'h000A};
        vecs[7]  = '{1'b0,  6,  6, 16'hFFFF, 16'h000A, 16'h000A};
        vecs[8]  = '{1'b1, 63,  0, 16'hBEEF, 16'h0000, 16'h0000};
        vecs[9]  = '{1'b1,  0, 63, 16'h1234, 16'h0000, 16'hBEEF};
        vecs[10] = '{1'b0, 63,  0, 16'h0000, 16'hBEEF, 16'h1234};
        vecs[11] = '{1'b1,  1,  6, 16'h5555, 16'h3D3A, 16'h000A};
        vecs[12] = '{1'b0,  1,  1, 16'h0000, 16'h5555, 16'h5555};

        nReset      = 1'b0;
        AddressA    = '0;
        AddressB    = '0;
        WriteData   = '0;
        WriteEnable = 1'b0;

        // Writes while held in reset must be dropped.
        @(negedge Clock);
        WriteEnable = 1'b1;
        AddressA    = 6'd9;
        WriteData   = 16'hDEAD;
        @(posedge Clock);
        #1;
        check("write_in_reset", ReadDataA, 16'h0000);
        WriteEnable = 1'b0;
        sweep_zero("reset_sweep");

        @(negedge Clock);
        nReset = 1'b1;

        // Main table: inputs applied after the falling edge, outputs checked
        // before the next rising edge, so expectations are pre-write contents.
        for (int v = 0; v < 13; v++) begin
            @(negedge Clock);
            WriteEnable = vecs[v].we;
            AddressA    = vecs[v].addr_a;
            AddressB    = vecs[v].addr_b;
            WriteData   = vecs[v].wdata;
            #1;
            check($sformatf("vec%0d_a", v), ReadDataA, vecs[v].exp_a);
            check($sformatf("vec%0d_b", v), ReadDataB, vecs[v].exp_b);
        end

        // No bypass: old value up to the edge, new value right after it.
        @(negedge Clock);
        WriteEnable = 1'b1;
        AddressA    = 6'd6;
        AddressB    = 6'd6;
        WriteData   = 16'hC0DE;
        #1;
        check("nobypass_before_a", ReadDataA, 16'h000A);
        @(posedge Clock);
        #1;
        check("nobypass_after_a", ReadDataA, 16'hC0DE);
        check("nobypass_after_b", ReadDataB, 16'hC0DE);

        // Reset between edges during a write: outputs clear before the next edge.
        @(negedge Clock);
        WriteEnable = 1'b1;
        AddressA    = 6'd63;
        AddressB    = 6'd0;
        WriteData   = 16'h7777;
        #1;
        check("midop_pre_a", ReadDataA, 16'hBEEF);
        check("midop_pre_b", ReadDataB, 16'h1234);
        #1;
        nReset = 1'b0;
        #1;
        check("midop_async_a", ReadDataA, 16'h0000);
        check("midop_async_b", ReadDataB, 16'h0000);
        @(posedge Clock);
        #1;
        check("midop_edge_a", ReadDataA, 16'h0000);
        WriteEnable = 1'b0;
        sweep_zero("midop_sweep");

        // First write after reset release behaves normally.
        @(negedge Clock);
        nReset      = 1'b1;
        WriteEnable = 1'b1;
        AddressA    = 6'd5;
        AddressB    = 6'd5;
        WriteData   = 16'hABCD;
        #1;
        check("post_reset_pre", ReadDataA, 16'h0000);
        @(posedge Clock);
        #1;
        check("post_reset_a", ReadDataA, 16'hABCD);
        check("post_reset_b", ReadDataB, 16'hABCD);
        @(negedge Clock);
        WriteEnable = 1'b0;
        AddressA    = 6'd63;
        #1;
        check("post_reset_63", ReadDataA, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
